// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM request arbiter: controller state codes,
// refresh threshold and the queued request record.
package sdram_pkg;

  // Controller state encodings observed by the arbiter
  localparam logic [4:0] IDLE      = 5'b00000;
  localparam logic [4:0] REF_START = 5'b00001;
  localparam logic [4:0] RD_ACT    = 5'b10000;
  localparam logic [4:0] RD_DONE   = 5'b10100;
  localparam logic [4:0] WR_ACT    = 5'b11000;

  // Refresh-due threshold; must agree with the controller
  localparam int REFRESH_THRESH = 519;

  // Request field widths carried through the FIFO
  localparam int REQ_ADDR_W = 22;
  localparam int REQ_DATA_W = 16;

  typedef struct packed {
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] wdata;
  } sdram_req_t;

endpackage

// File: rtl/sdram_req_fifo.sv
// Small synchronous request FIFO: head-of-queue output, full/empty flags.
// A push while full and a pop while empty are both ignored.
module sdram_req_fifo
  import sdram_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       push,
  input  logic       pop,
  input  sdram_req_t din,
  output sdram_req_t head,
  output logic       full,
  output logic       empty
);

  localparam int PW = $clog2(DEPTH);

  sdram_req_t     mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy update; reset empties the queue
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage
  // NOTE: storage is deliberately not reset; stale entries are unreachable
  // once the pointers and count clear, and skipping reset keeps it RAM-mappable.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Host-side request arbiter feeding the SDRAM controller FSM.
// Queues host requests, presents rd_enable/wr_enable from the queue head,
// holds command address/data stable, and returns read data.
// Optional build macro: SDRAM_ARB_STATS_EN adds stat_rd/stat_wr/stat_ref.
module sdram_req_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W         = 22,
  parameter int DATA_W         = 16,
  parameter int DEPTH          = 4,
  parameter int REFRESH_THRESH = sdram_pkg::REFRESH_THRESH
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [4:0]        ctrl_state,
  output logic [9:0]        refresh_cnt,
  output logic              rd_enable,
  output logic              wr_enable,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] dq_in,
`ifdef SDRAM_ARB_STATS_EN
  output logic [15:0]       stat_rd,
  output logic [15:0]       stat_wr,
  output logic [15:0]       stat_ref,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata
);

  // The queued record is defined once in the package; widths must agree.
  if (ADDR_W != REQ_ADDR_W || DATA_W != REQ_DATA_W) begin : g_width_check
    $error("sdram_req_arbiter: ADDR_W/DATA_W must match sdram_pkg request widths");
  end

  sdram_req_t din;
  sdram_req_t head;
  logic       full;
  logic       empty;
  logic       pop_req;
  logic [4:0] prev_state;

  assign din       = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign req_ready = !full;
  assign rd_enable = !empty && !head.we;
  assign wr_enable = !empty &&  head.we;

  // A command is consumed when the controller first leaves IDLE into an activate
  assign pop_req = ((ctrl_state == RD_ACT) || (ctrl_state == WR_ACT)) &&
                   (prev_state == IDLE);

  sdram_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .push    (req_valid && req_ready),
    .pop     (pop_req),
    .din     (din),
    .head    (head),
    .full    (full),
    .empty   (empty)
  );

  // Controller state history, refresh age, command latch and read return
  // NOTE: all registered state uses non-blocking assignment so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      prev_state  <= IDLE;
      refresh_cnt <= '0;
      cmd_addr    <= '0;
      cmd_wdata   <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      prev_state <= ctrl_state;

      if (ctrl_state == REF_START)   refresh_cnt <= '0;
      else if (refresh_cnt != '1)    refresh_cnt <= refresh_cnt + 1'b1;

      if (ctrl_state == IDLE && !empty) begin
        cmd_addr  <= head.addr;
        cmd_wdata <= head.wdata;
      end

      rsp_valid <= (ctrl_state == RD_DONE);
      if (ctrl_state == RD_DONE) rsp_rdata <= dq_in;
    end
  end

`ifdef SDRAM_ARB_STATS_EN
  // Saturating activity counters: pops by type and refresh entries
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      stat_rd  <= '0;
      stat_wr  <= '0;
      stat_ref <= '0;
    end else begin
      if (pop_req && !empty && !head.we && stat_rd != '1) stat_rd <= stat_rd + 1'b1;
      if (pop_req && !empty &&  head.we && stat_wr != '1) stat_wr <= stat_wr + 1'b1;
      if (ctrl_state == REF_START && prev_state != REF_START && stat_ref != '1)
        stat_ref <= stat_ref + 1'b1;
    end
  end
`endif

  // Popping an empty queue means the controller started a command unasked
  a_no_empty_pop: assert property (@(posedge CLK) disable iff (!RESET_N)
    pop_req |-> !empty)
    else $error("sdram_req_arbiter: pop requested with empty request FIFO");

endmodule

// File: doc/sdram_req_arbiter.md
# sdram_req_arbiter

Upstream companion to the SDRAM controller FSM. Accepts host read/write requests over a valid/ready handshake, buffers them in a 4-entry FIFO, and drives the controller's `rd_enable`, `wr_enable` and `refresh_cnt` inputs. It holds the address and write data stable for the full command sequence, pops a request when the controller leaves IDLE for a read or write, and returns read data to the host.

## Interface
Parameters:
- `ADDR_W`, 22, host word address width
- `DATA_W`, 16, SDRAM data width
- `DEPTH`, 4, request FIFO entries (power of two)
- `REFRESH_THRESH`, 519, refresh-due threshold; must match the controller

Ports:
- `CLK`  in  1  sole clock; all state updates on rising edge
- `RESET_N`  in  1  synchronous, active-low reset
- `req_valid`  in  1  host request valid
- `req_ready`  out  1  FIFO not full
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_W  request address
- `req_wdata`  in  DATA_W  write data
- `ctrl_state`  in  5  controller current state
- `refresh_cnt`  out  10  cycles since last refresh
- `rd_enable`  out  1  head entry is a read
- `wr_enable`  out  1  head entry is a write
- `cmd_addr`  out  ADDR_W  address for the current command
- `cmd_wdata`  out  DATA_W  write data for the current command
- `dq_in`  in  DATA_W  SDRAM read data bus
- `rsp_valid`  out  1  one-cycle read-data strobe
- `rsp_rdata`  out  DATA_W  read data

## Operation
- Controller state codes used: IDLE 5'b00000, REF_START 5'b00001, RD_ACT 5'b10000, RD_DONE 5'b10100, WR_ACT 5'b11000.
- Reset (RESET_N low at an edge): FIFO empty. `refresh_cnt`, `cmd_addr`, `cmd_wdata`, `rsp_rdata` and `prev_state` go to 0. `prev_state` resets to IDLE, which is 0. `rsp_valid` goes to 0.
- Reset takes priority over every other event. Reset mid-operation discards all queued and in-flight requests without a response.
- Refresh counter:
  - Clears to 0 on any cycle where `ctrl_state`==REF_START.
  - Otherwise increments by 1 and saturates at 1023.
  - Is not gated by FIFO state.
- FIFO:
  - `req_ready` = !full. Push on `req_valid && req_ready`.
  - Each entry holds {we, addr, wdata}.
  - Push and pop in the same cycle leave the count unchanged.
  - No push is possible when full, even with a simultaneous pop.
- Enables (combinational from the head):
  - `rd_enable` = !empty && !head.we.
  - `wr_enable` = !empty && head.we.
  - The two are never high together.
  - Refresh priority belongs to the controller and is not gated here.
- Command latch: on each cycle with `ctrl_state`==IDLE and the FIFO non-empty, `cmd_addr`/`cmd_wdata` load from the head. Otherwise they hold.
- Pop: on a cycle where `ctrl_state` is RD_ACT or WR_ACT and `prev_state`==IDLE. `prev_state` is `ctrl_state` registered. A pop on an empty FIFO is ignored; it is a protocol error, flagged by an assertion.
- Read response: on a cycle with `ctrl_state`==RD_DONE, the next edge sets `rsp_valid`=1 and `rsp_rdata`=`dq_in`. `rsp_valid` returns to 0 after one cycle.

## Timing
- Request to `rd_enable`/`wr_enable`: 1 cycle. Push at edge N, enable visible after edge N.
- `cmd_addr` is valid from the first RD_ACT/WR_ACT cycle through the return to IDLE.
- Pop completes at the edge ending the first RD_ACT/WR_ACT cycle. The new head is visible by the next IDLE.
- `rsp_valid` appears exactly 1 cycle after RD_DONE.
- `refresh_cnt` reads 0 in the cycle after REF_START.

## Configuration
- `SDRAM_ARB_STATS_EN` defined:
  - Adds outputs `stat_rd`, `stat_wr`, `stat_ref`, each 16 bits.
  - These are saturating counts of pops with we=0, pops with we=1, and REF_START entries.
  - All three clear on reset.
- `SDRAM_ARB_STATS_EN` undefined: the ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- Package `sdram_pkg` holds:
  - The state-code localparams: IDLE, REF_START, RD_ACT, RD_DONE, WR_ACT.
  - `REFRESH_THRESH`=519.
  - The `sdram_req_t` struct {we, addr, wdata}.
- Sub-module `sdram_req_fifo` (parameter DEPTH): synchronous FIFO with full/empty flags, head output, push/pop. The top level instantiates it once.

## Test plan
- Reset then idle for 600 cycles with `ctrl_state`=IDLE → `refresh_cnt`=600, `req_ready`=1, both enables 0.
- Push read addr 0x00123 → next cycle `rd_enable`=1. Drive IDLE→RD_ACT → `cmd_addr`=0x00123 during RD_ACT; FIFO empty after pop.
- Push 4 writes back-to-back → `req_ready`=0 after the 4th. A 5th `req_valid` is not accepted until the first pop.
- Write 0xBEEF @0x3 queued behind read @0x1 → `rd_enable` first. After that pop, `wr_enable`=1 and `cmd_wdata`=0xBEEF.
- `ctrl_state`=RD_DONE with `dq_in`=0xA5A5 → `rsp_valid`=1 for exactly one cycle, `rsp_rdata`=0xA5A5.
- `ctrl_state`=REF_START at `refresh_cnt`=519 → 0 next cycle. Assert RESET_N low while 2 entries are queued → empty, `req_ready`=1, all outputs 0.
